// File: rtl/onehot_priority_mux.sv
`default_nettype none
// ============================================================================
// Module   : onehot_priority_mux
// Purpose  : Strict-priority N-way request arbiter with a one-hot data mux.
//            Index 0 has the highest priority. The arbiter picks one requester
//            per cycle and steers that requester's data slice to the output.
//            With ONEHOT_PRIORITY_HOLD_EN defined, a registered last-grant
//            lets the current owner keep the grant until canchange is high.
//            With ONEHOT_PRIORITY_HOLD_EN undefined, the block is purely
//            combinational. clk, rst_n and canchange are kept as ports but
//            are unused in that build.
// Macro    : ONEHOT_PRIORITY_HOLD_EN  - enables the last-grant hold register
// Ports    : clk        in   1                  clock
//            rst_n      in   1                  async active-low reset
//            canchange  in   1                  1 = grant may move this cycle
//            req        in   N_INPUTS           request vector
//            gnt        out  N_INPUTS           one-hot (or zero) grant
//            gnt_any    out  1                  |gnt
//            in         in   N_INPUTS*W_INPUT   data; slice i = in[i*W +: W]
//            out        out  W_INPUT            slice selected by gnt (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module onehot_priority_mux #(
  parameter int N_INPUTS = 2,
  parameter int W_INPUT  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          canchange,
  input  logic [N_INPUTS-1:0]           req,
  output logic [N_INPUTS-1:0]           gnt,
  output logic                          gnt_any,
  input  logic [N_INPUTS*W_INPUT-1:0]   in,
  output logic [W_INPUT-1:0]            out
);

  localparam logic [N_INPUTS-1:0] C_ONE = N_INPUTS'(1);

  logic [N_INPUTS-1:0] w_prio;

  // Lowest set bit of req. When req is all zero, ~req + 1 wraps to zero, so
  // the AND yields zero without any special case.
  always_comb begin
    w_prio = req & (~req + C_ONE);
  end

`ifdef ONEHOT_PRIORITY_HOLD_EN

  logic [N_INPUTS-1:0] last_gnt_q;
  logic [N_INPUTS-1:0] last_gnt_d;
  logic                w_hold;

  // The owner keeps the grant only while it is still requesting and the
  // caller has not opened a switch point. A holder that drops its request
  // releases immediately, independent of canchange.
  always_comb begin
    w_hold = (|(last_gnt_q & req)) && !canchange;
    gnt    = w_hold ? last_gnt_q : w_prio;
  end

  always_comb begin
    last_gnt_d = gnt;
  end

  // Asynchronous clear so that asserting rst_n mid-hold drops the hold at
  // once and the grant falls back to plain priority before the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

`else

  logic w_unused_ports;

  always_comb begin
    gnt = w_prio;
  end

  assign w_unused_ports = ^{clk, rst_n, canchange};

`endif

  always_comb begin
    gnt_any = |gnt;
  end

  // AND-OR mux: gnt is one-hot or zero, so at most one slice contributes.
  always_comb begin
    out = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      out = out | (in[i*W_INPUT +: W_INPUT] & {W_INPUT{gnt[i]}});
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_priority_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_priority_mux
// Purpose  : Self-checking bench for onehot_priority_mux. A 2-input instance
//            is driven from a vector table; a 4-input instance gets a short
//            hand sequence and a random sweep checked against a small model.
//            Expected values follow ONEHOT_PRIORITY_HOLD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_priority_mux;

`ifdef ONEHOT_PRIORITY_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cc2, cc4;
  logic [1:0]  req2, gnt2;
  logic [3:0]  req4, gnt4;
  logic        gnt_any2, gnt_any4;
  logic [15:0] in2;
  logic [31:0] in4;
  logic [7:0]  out2, out4;

  onehot_priority_mux #(.N_INPUTS(2), .W_INPUT(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .canchange(cc2), .req(req2),
    .gnt(gnt2), .gnt_any(gnt_any2), .in(in2), .out(out2)
  );

  onehot_priority_mux #(.N_INPUTS(4), .W_INPUT(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .canchange(cc4), .req(req4),
    .gnt(gnt4), .gnt_any(gnt_any4), .in(in4), .out(out4)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  req;
    logic        cc;
    logic [15:0] din;
    logic [1:0]  gnt_hold;
    logic [1:0]  gnt_comb;
    logic [7:0]  out_hold;
    logic [7:0]  out_comb;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic       any;
    logic [7:0] out;
    int         inst;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] m_last4  = '0;

  function automatic logic [3:0] model4(logic [3:0] r, logic c, logic [3:0] last);
    logic [3:0] prio;
    prio = r & (~r + 4'd1);
    if (HOLD_EN && ((last & r) != 4'd0) && !c) return last;
    return prio;
  endfunction

  function automatic logic [7:0] mux4(logic [31:0] d, logic [3:0] g);
    logic [7:0] o;
    o = 8'h00;
    for (int i = 0; i < 4; i++) if (g[i]) o = o | d[i*8 +: 8];
    return o;
  endfunction

  task automatic check_one(string name, string field, logic [7:0] act, logic [7:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s %s actual=%h required=%h", name, field, act, req_v);
    end
  endtask

  task automatic pop_and_check();
    exp_t       e;
    logic [3:0] ag;
    logic       aa;
    logic [7:0] ao;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    if (e.inst == 2) begin
      ag = {2'b00, gnt2}; aa = gnt_any2; ao = out2;
    end else begin
      ag = gnt4; aa = gnt_any4; ao = out4;
    end
    check_one(e.name, "gnt",     {4'h0, ag}, {4'h0, e.gnt});
    check_one(e.name, "gnt_any", {7'h0, aa}, {7'h0, e.any});
    check_one(e.name, "out",     ao,         e.out);
  endtask

  // Drive the 4-input instance for one cycle and track its last grant.
  task automatic step4(string name, logic [3:0] r, logic c, logic [31:0] d,
                       logic [3:0] eg, logic [7:0] eo);
    exp_t e;
    @(negedge clk);
    req4 = r; cc4 = c; in4 = d;
    e.gnt = eg; e.any = |eg; e.out = eo; e.inst = 4; e.name = name;
    sb.push_back(e);
    #1;
    pop_and_check();
    m_last4 = eg;
  endtask

  vec_t vecs[15];

  initial begin
    exp_t       e;
    logic [3:0] r, g;
    logic       c;
    logic [31:0] d;

    rst_n = 1'b0;
    req2 = '0; cc2 = 1'b0; in2 = '0;
    req4 = '0; cc4 = 1'b0; in4 = '0;

    //          rst  req    cc    din        g_hold g_comb o_hold o_comb
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 16'hB1A0, 2'b00, 2'b00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 2'b00, 1'b0, 16'hB1A0, 2'b00, 2'b00, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 16'hB1A0, 2'b10, 2'b10, 8'hB1, 8'hB1};
    vecs[3]  = '{1'b1, 2'b11, 1'b0, 16'hB1A0, 2'b10, 2'b01, 8'hB1, 8'hA0};
    vecs[4]  = '{1'b1, 2'b11, 1'b1, 16'hB1A0, 2'b01, 2'b01, 8'hA0, 8'hA0};
    vecs[5]  = '{1'b1, 2'b11, 1'b0, 16'h5C3E, 2'b01, 2'b01, 8'h3E, 8'h3E};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 16'h5C3E, 2'b10, 2'b10, 8'h5C, 8'h5C};
    vecs[7]  = '{1'b1, 2'b11, 1'b0, 16'hB1A0, 2'b10, 2'b01, 8'hB1, 8'hA0};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 16'hB1A0, 2'b01, 2'b01, 8'hA0, 8'hA0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 16'hB1A0, 2'b10, 2'b10, 8'hB1, 8'hB1};
    vecs[10] = '{1'b1, 2'b11, 1'b0, 16'hB1A0, 2'b10, 2'b01, 8'hB1, 8'hA0};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 16'hB1A0, 2'b01, 2'b01, 8'hA0, 8'hA0};
    vecs[12] = '{1'b1, 2'b10, 1'b0, 16'hB1A0, 2'b10, 2'b10, 8'hB1, 8'hB1};
    vecs[13] = '{1'b1, 2'b11, 1'b0, 16'hB1A0, 2'b10, 2'b01, 8'hB1, 8'hA0};
    vecs[14] = '{1'b1, 2'b00, 1'b1, 16'hB1A0, 2'b00, 2'b00, 8'h00, 8'h00};

    // 2-input table: reset, hold, canchange release, holder drop, async reset.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      req2  = vecs[i].req;
      cc2   = vecs[i].cc;
      in2   = vecs[i].din;
      e.gnt  = {2'b00, HOLD_EN ? vecs[i].gnt_hold : vecs[i].gnt_comb};
      e.any  = |e.gnt;
      e.out  = HOLD_EN ? vecs[i].out_hold : vecs[i].out_comb;
      e.inst = 2;
      e.name = $sformatf("vec%0d", i);
      sb.push_back(e);
      #1;
      pop_and_check();
    end
    rst_n = 1'b1;
    m_last4 = 4'h0;

    // 4-input boundary cases.
    step4("n4_req1100", 4'b1100, 1'b0, 32'h83422110, 4'b0100, 8'h42);
    step4("n4_req0000", 4'b0000, 1'b0, 32'h83422110, 4'b0000, 8'h00);
    step4("n4_req1000", 4'b1000, 1'b0, 32'h83422110, 4'b1000, 8'h83);
    step4("n4_req1111", 4'b1111, 1'b1, 32'h83422110, 4'b0001, 8'h10);

    // Random sweep against the model, plus structural invariants.
    for (int k = 0; k < 80; k++) begin
      r = 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 3) == 0);
      d = $urandom;
      g = model4(r, c, m_last4);
      step4($sformatf("rnd%0d", k), r, c, d, g, mux4(d, g));
      checks++;
      if (!$onehot0(gnt4) || ((gnt4 & ~r) != 4'd0)) begin
        failures++;
        $display("FAIL rnd%0d_invariant actual=%b required_subset_of=%b", k, gnt4, r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
